// File: rtl/pipe_stage_reg_hs.sv
// pipe_stage_reg_hs
//   Inter-stage pipeline register with a valid/ready handshake and a 2-entry
//   skid buffer. It carries a payload, a control-bit bundle and an instruction
//   word. Optional statistics counters are enabled by defining the macro
//   PIPE_STAGE_STATS_EN. Without it, stall_cnt and bubble_cnt are tied to 0.
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready and out_valid are decoded from the state register
//   only, so there is no combinational path from the in_* inputs to the
//   out_* outputs. Held outputs stay stable while out_valid && !out_ready.
//
//   The state (EMPTY/ONE/TWO) is exposed directly as occupancy. "main" always
//   holds the older entry. "skid" only ever refills main and is never
//   presented downstream.
module pipe_stage_reg_hs #(
  parameter int unsigned      DATA_W = 64,
  parameter int unsigned      CTRL_W = 8,
  parameter int unsigned      IR_W   = 16,
  parameter logic [IR_W-1:0]  NOP_IR = 16'hF000,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [IR_W-1:0]   in_ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [IR_W-1:0]   out_ir,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [IR_W-1:0]   main_ir_q,   skid_ir_q;

  logic acc, drn;
  logic main_ld_in, main_ld_skid, skid_ld_in;

  // Handshake flags come from the state register only.
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    acc       = in_valid && in_ready;
    drn       = out_valid && out_ready;
  end

  // Next-state and load-enable decode. Flush overrides everything, so any
  // entry offered in the flush cycle is dropped.
  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld_in   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d    = ONE;
            main_ld_in = 1'b1;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_ld_in = 1'b1;
          end else if (acc) begin
            state_d    = TWO;
            skid_ld_in = 1'b1;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drn) begin
            state_d      = ONE;
            main_ld_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Main entry register. It is the only source of out_*.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_ir_q   <= '0;
    end else if (main_ld_in) begin
      main_data_q <= in_data;
      main_ctrl_q <= in_ctrl;
      main_ir_q   <= in_ir;
    end else if (main_ld_skid) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
      main_ir_q   <= skid_ir_q;
    end
  end

  // Skid entry register. It catches the entry accepted while main is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_ir_q   <= '0;
    end else if (skid_ld_in) begin
      skid_data_q <= in_data;
      skid_ctrl_q <= in_ctrl;
      skid_ir_q   <= in_ir;
    end
  end

  // Output presentation. With no valid entry, a bubble is shown on ctrl/ir.
  always_comb begin
    occupancy = state_q;
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_ir    = out_valid ? main_ir_q   : NOP_IR;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  // Saturating stall/bubble counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}}))
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  // Drive the counter ports from the counter registers.
  always_comb begin
    stall_cnt  = stall_cnt_q;
    bubble_cnt = bubble_cnt_q;
  end
`else
  // Statistics are not built, so the counter ports read as zero.
  always_comb begin
    stall_cnt  = '0;
    bubble_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg_hs.sv
// Directed plus randomized-handshake bench for pipe_stage_reg_hs.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// after the edge has settled.
module tb_pipe_stage_reg_hs;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int IR_W   = 16;
  localparam int CNT_W  = 4;
  localparam int W      = DATA_W + CTRL_W + IR_W;
  localparam logic [IR_W-1:0] NOP = 16'hF000;
`ifdef PIPE_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] SAT = 4'hF;
`else
  localparam logic [CNT_W-1:0] SAT = 4'h0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [IR_W-1:0]   in_ir = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [IR_W-1:0]   out_ir;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_reg_hs #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .IR_W(IR_W), .NOP_IR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_ir(in_ir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_ir(out_ir),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic [IR_W-1:0] ir);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    in_ir    = ir;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] cur, prev_out, item;
  logic         prev_stall;
  logic         do_acc, do_drn;
  int           guard;

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_occupancy", W'(occupancy), W'(0));
    check("rst_out_ir",    W'(out_ir),    W'(NOP));
    check("rst_out_ctrl",  W'(out_ctrl),  W'(0));
    check("rst_out_data",  W'(out_data),  W'(0));
    check("rst_stall_cnt", W'(stall_cnt), W'(0));
    check("rst_bubble_cnt", W'(bubble_cnt), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- streaming 0xA1..0xA8 ----------------
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(8'hA0 + i), CTRL_W'(i), IR_W'(16'h1000 + i));
      check("stream_in_ready", W'(in_ready), W'(1));
      tick();
      check("stream_out_valid", W'(out_valid), W'(1));
      check("stream_out_data",  W'(out_data),  W'(8'hA0 + i));
      check("stream_out_ir",    W'(out_ir),    W'(16'h1000 + i));
    end
    drive(1'b0, '0, '0, '0);
    tick();
    check("stream_end_valid", W'(out_valid), W'(0));
    check("bubble_ir",        W'(out_ir),    W'(NOP));
    check("bubble_ctrl",      W'(out_ctrl),  W'(0));
    check("bubble_data_hold", W'(out_data),  W'(8'hA8));

    // ---------------- back-pressure ----------------
    out_ready = 1'b0;
    drive(1'b1, 64'hB1, 8'h11, 16'h2001);
    tick();
    check("bp_occ1", W'(occupancy), W'(1));
    drive(1'b1, 64'hB2, 8'h12, 16'h2002);
    tick();
    check("bp_occ2",      W'(occupancy), W'(2));
    check("bp_in_ready0", W'(in_ready),  W'(0));
    check("bp_head",      W'(out_data),  W'(64'hB1));
    drive(1'b1, 64'hB3, 8'h13, 16'h2003);
    tick();
    check("bp_hold_occ",  W'(occupancy), W'(2));
    check("bp_hold_data", W'(out_data),  W'(64'hB1));
    check("bp_hold_ctrl", W'(out_ctrl),  W'(8'h11));
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    tick();
    check("bp_rel_data1", W'(out_data),  W'(64'hB2));
    check("bp_rel_ir1",   W'(out_ir),    W'(16'h2002));
    check("bp_rel_occ1",  W'(occupancy), W'(1));
    tick();
    check("bp_rel_occ0",  W'(occupancy), W'(0));
    check("bp_rel_valid", W'(out_valid), W'(0));

    // ---------------- flush at occupancy 2 ----------------
    out_ready = 1'b0;
    drive(1'b1, 64'hC1, 8'h21, 16'h3001);
    tick();
    drive(1'b1, 64'hC2, 8'h22, 16'h3002);
    tick();
    check("fl_pre_occ", W'(occupancy), W'(2));
    flush = 1'b1;
    drive(1'b1, 64'hC3, 8'h23, 16'h3003);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("fl_occ",      W'(occupancy), W'(0));
    check("fl_ctrl",     W'(out_ctrl),  W'(0));
    check("fl_ir",       W'(out_ir),    W'(NOP));
    check("fl_in_ready", W'(in_ready),  W'(1));
    tick();
    check("fl_dropped",  W'(occupancy), W'(0));

    // ---------------- stats saturation ----------------
    for (int i = 0; i < 16; i++) tick();
    check("bubble_sat", W'(bubble_cnt), W'(SAT));
    drive(1'b1, 64'hD1, 8'h31, 16'h4001);
    tick();
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    check("stall_sat",  W'(stall_cnt), W'(SAT));
    check("stall_hold", W'(out_data),  W'(64'hD1));

    // ---------------- async reset mid-stream at occupancy 2 ----------------
    drive(1'b1, 64'hE1, 8'h41, 16'h5001);
    tick();
    check("ar_pre_occ", W'(occupancy), W'(2));
    drive(1'b1, 64'hE2, 8'h42, 16'h5002);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid",     W'(out_valid), W'(0));
    check("ar_ir",        W'(out_ir),    W'(NOP));
    check("ar_in_ready",  W'(in_ready),  W'(1));
    check("ar_occ",       W'(occupancy), W'(0));
    check("ar_data",      W'(out_data),  W'(0));
    check("ar_stall_cnt", W'(stall_cnt), W'(0));
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_post_occ", W'(occupancy), W'(0));

    // ---------------- random valid/ready vs scoreboard ----------------
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
            CTRL_W'($urandom_range(0, 255)), IR_W'($urandom_range(0, 16'hFFFF)));
      out_ready = ($urandom_range(0, 99) < 60);
      #1;
      cur = {out_data, out_ctrl, out_ir};
      if (prev_stall) check("rnd_stable", cur, prev_out);
      do_drn = out_valid && out_ready;
      do_acc = in_valid && in_ready;
      if (do_drn) begin
        if (exp_q.size() == 0) check("rnd_unexpected", cur, '0);
        else begin
          item = exp_q.pop_front();
          check("rnd_order", cur, item);
        end
      end
      if (do_acc) exp_q.push_back({in_data, in_ctrl, in_ir});
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      tick();
    end

    // Drain what is left, bounded.
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    guard = 0;
    #1;
    while (out_valid && guard < 10) begin
      cur = {out_data, out_ctrl, out_ir};
      if (exp_q.size() == 0) check("drain_unexpected", cur, '0);
      else begin
        item = exp_q.pop_front();
        check("drain_order", cur, item);
      end
      tick();
      #1;
      guard++;
    end
    check("drain_timeout", W'(guard < 10), W'(1));
    check("drain_empty",   W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
